// File: rtl/general_defs_pkg.sv
// Shared pipeline definitions: stall encoding from the hazard detector and the fetch entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package GENERAL_DEFS;

  // Hazard detector's stall request. Decode and fetch both consume this encoding.
  typedef enum logic {
    NO_STALL_PIPELINE = 1'b0,
    STALL_PIPELINE    = 1'b1
  } stall_pipeline_sig;

  // Architectural widths of the default core configuration.
  localparam int unsigned PC_WIDTH_DEF    = 32;
  localparam int unsigned INSTR_WIDTH_DEF = 16;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_WIDTH_DEF-1:0] instr;
    logic [PC_WIDTH_DEF-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetch response that lands while the pipeline is frozen.
// Latency: entry visible on entry_o the cycle after load_i.
// Backpressure: none of its own; the owner guarantees it never loads while already full.
module fetch_skid_buffer
  import GENERAL_DEFS::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   load_i,
  input  logic   clear_i,
  input  entry_t entry_i,
  output logic   valid_o,
  output entry_t entry_o
);

  entry_t entry_q;
  logic   valid_q;

  // Clear beats load so a redirect always empties the buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues imem reads, drives IF/ID; optional perf counters under FETCH_PERF_CNT_EN.
// Latency: request in cycle T, data from imem in T+1, on instr_o in T+2; a redirect costs one bubble.
// Backpressure: stall freezes PC and IF/ID; the in-flight response is parked in a one-entry skid buffer.
module fetch_stage
  import GENERAL_DEFS::*;
#(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  stall_pipeline_sig      stall_pipeline_i,
  input  logic                   branch_taken_i,
  input  logic [PC_WIDTH-1:0]    branch_target_i,
  output logic                   imem_rd_en_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic [INSTR_WIDTH-1:0] imem_data_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    instr_pc_o,
  output logic                   instr_valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cycles_o,
  output logic [31:0]            redirect_cnt_o
`endif
);

  // Entry shape follows the module parameters so non-default widths still line up.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } if_entry_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INSTR_WIDTH / 8);

  logic [PC_WIDTH-1:0] pc_q;
  logic                pending_q;
  logic [PC_WIDTH-1:0] pending_pc_q;
  if_entry_t           ifid_q;
  logic                ifid_valid_q;

  logic                stall;
  logic                redirect;
  logic                advance;
  if_entry_t           resp_entry;
  logic                skid_load;
  logic                skid_clear;
  logic                skid_valid;
  if_entry_t           skid_entry;

  // Redirect outranks stall; advance means a plain sequential cycle.
  assign stall    = (stall_pipeline_i == STALL_PIPELINE);
  assign redirect = branch_taken_i;
  assign advance  = !redirect && !stall;

  assign resp_entry = '{instr: imem_data_i, pc: pending_pc_q};

  // Only a stall with a response arriving parks it; draining happens on the first free cycle.
  assign skid_load  = stall && !redirect && pending_q;
  assign skid_clear = redirect || (advance && skid_valid);

  assign imem_rd_en_o = rst_n_i && (redirect || !stall);
  assign imem_addr_o  = redirect ? branch_target_i : pc_q;

  fetch_skid_buffer #(
    .entry_t (if_entry_t)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .entry_i (resp_entry),
    .valid_o (skid_valid),
    .entry_o (skid_entry)
  );

  // PC and in-flight tracking: at most one request outstanding at any time.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q         <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
    end else if (redirect) begin
      pc_q         <= branch_target_i + PC_STEP;
      pending_q    <= 1'b1;
      pending_pc_q <= branch_target_i;
    end else if (stall) begin
      pending_q    <= 1'b0;
    end else begin
      pc_q         <= pc_q + PC_STEP;
      pending_q    <= 1'b1;
      pending_pc_q <= pc_q;
    end
  end

  // IF/ID register: skid entry first, then the live response; bubble data is left untouched.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ifid_q       <= '0;
      ifid_valid_q <= 1'b0;
    end else if (redirect) begin
      ifid_valid_q <= 1'b0;
    end else if (advance) begin
      if (skid_valid) begin
        ifid_q       <= skid_entry;
        ifid_valid_q <= 1'b1;
      end else if (pending_q) begin
        ifid_q       <= resp_entry;
        ifid_valid_q <= 1'b1;
      end else begin
        ifid_valid_q <= 1'b0;
      end
    end
  end

  assign instr_o       = ifid_q.instr;
  assign instr_pc_o    = ifid_q.pc;
  assign instr_valid_o = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redirect_cnt_q;

  // Saturating event counters; a stall overridden by a redirect counts only as a redirect.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (stall && !redirect && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect && (redirect_cnt_q != '1)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table plus a reset-during-stall/branch sequence.
// Latency: a synchronous imem model answers one cycle after each read.
// Backpressure: stall and branch are driven directly from the vector table.
module tb_fetch_stage;
  import GENERAL_DEFS::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  stall_pipeline_sig stall = NO_STALL_PIPELINE;
  logic              br = 1'b0;
  logic [31:0]       tgt = 32'h0;

  logic        rd_en0, rd_en1, valid0, valid1;
  logic [31:0] addr0, addr1, pc0, pc1;
  logic [15:0] data0, data1, instr0, instr1;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] sc0, rc0, sc1, rc1;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_stage #(.PC_WIDTH(32), .INSTR_WIDTH(16), .RESET_PC(32'h0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_pipeline_i(stall),
    .branch_taken_i(br), .branch_target_i(tgt),
    .imem_rd_en_o(rd_en0), .imem_addr_o(addr0), .imem_data_i(data0),
    .instr_o(instr0), .instr_pc_o(pc0), .instr_valid_o(valid0)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles_o(sc0), .redirect_cnt_o(rc0)
`endif
  );

  // Second instance checks PC wrap-around from the top of the address space.
  fetch_stage #(.PC_WIDTH(32), .INSTR_WIDTH(16), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .stall_pipeline_i(NO_STALL_PIPELINE),
    .branch_taken_i(1'b0), .branch_target_i(32'h0),
    .imem_rd_en_o(rd_en1), .imem_addr_o(addr1), .imem_data_i(data1),
    .instr_o(instr1), .instr_pc_o(pc1), .instr_valid_o(valid1)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles_o(sc1), .redirect_cnt_o(rc1)
`endif
  );

  // Synchronous instruction memory: word at addr reads as 0x1000 + addr.
  always @(posedge clk) begin
    if (rd_en0) data0 <= 16'h1000 + addr0[15:0];
    if (rd_en1) data1 <= 16'h1000 + addr1[15:0];
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        rden;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t        vecs[22];
  logic [31:0] wrap_seq[3];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic r, input logic [31:0] a,
                              input logic v, input logic [31:0] p);
    vec_t x;
    x.stall = s; x.br = b; x.tgt = t; x.rden = r; x.addr = a; x.valid = v; x.pc = p;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    wrap_seq[0] = 32'hFFFF_FFFC;
    wrap_seq[1] = 32'hFFFF_FFFE;
    wrap_seq[2] = 32'h0000_0000;

    //              stall br   tgt       rden  addr    valid pc
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h00);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h02, 1'b0, 32'h00);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 1'b1, 32'h00);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h06, 1'b1, 32'h02);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 32'h04);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b1, 32'h06);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b1, 32'h06);
    vecs[7]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b1, 32'h06);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h0A, 1'b1, 32'h06);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 32'h08);
    vecs[10] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h0E, 1'b1, 32'h0A);
    vecs[11] = mk(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h0C);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h42, 1'b0, 32'h00);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h40);
    vecs[14] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h46, 1'b1, 32'h42);
    vecs[15] = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b1, 32'h44);
    vecs[16] = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b1, 32'h44);
    vecs[17] = mk(1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h44);
    vecs[18] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h42, 1'b0, 32'h00);
    vecs[19] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h44, 1'b1, 32'h40);
    vecs[20] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h46, 1'b1, 32'h42);
    vecs[21] = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b1, 32'h44);

    // Held in reset for a few edges; outputs must read as reset values.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset rd_en", {31'b0, rd_en0}, 32'h0);
    chk("reset valid", {31'b0, valid0}, 32'h0);
    chk("reset instr", {16'b0, instr0}, 32'h0);
    chk("reset pc", pc0, 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 22; k++) begin
      if (k > 0) @(negedge clk);
      stall = vecs[k].stall ? STALL_PIPELINE : NO_STALL_PIPELINE;
      br    = vecs[k].br;
      tgt   = vecs[k].tgt;
      #1;
      chk($sformatf("c%0d rd_en", k), {31'b0, rd_en0}, {31'b0, vecs[k].rden});
      if (vecs[k].rden) chk($sformatf("c%0d addr", k), addr0, vecs[k].addr);
      chk($sformatf("c%0d valid", k), {31'b0, valid0}, {31'b0, vecs[k].valid});
      if (vecs[k].valid) begin
        chk($sformatf("c%0d pc", k), pc0, vecs[k].pc);
        chk($sformatf("c%0d instr", k), {16'b0, instr0}, {16'b0, 16'h1000 + vecs[k].pc[15:0]});
      end
      if (k < 3) chk($sformatf("wrap c%0d addr", k), addr1, wrap_seq[k]);
      if (k >= 2 && k < 5) begin
        chk($sformatf("wrap c%0d valid", k), {31'b0, valid1}, 32'h1);
        chk($sformatf("wrap c%0d pc", k), pc1, wrap_seq[k-2]);
      end
    end

    // Still stalled with the skid holding 0x46; now reset together with a branch request.
    @(negedge clk); #1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf stall_cycles", sc0, 32'd6);
    chk("perf redirect_cnt", rc0, 32'd2);
`endif
    rst_n = 1'b0;
    br    = 1'b1;
    tgt   = 32'h80;
    #1;
    chk("rst+br rd_en", {31'b0, rd_en0}, 32'h0);

    @(negedge clk); #1;
    chk("post-rst valid", {31'b0, valid0}, 32'h0);
    chk("post-rst instr", {16'b0, instr0}, 32'h0);
    chk("post-rst pc", pc0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("post-rst stall_cycles", sc0, 32'h0);
    chk("post-rst redirect_cnt", rc0, 32'h0);
`endif
    rst_n = 1'b1;
    br    = 1'b0;
    tgt   = 32'h0;
    stall = NO_STALL_PIPELINE;
    #1;
    chk("restart rd_en", {31'b0, rd_en0}, 32'h1);
    chk("restart addr", addr0, 32'h0);

    @(negedge clk); #1;
    chk("restart c1 valid", {31'b0, valid0}, 32'h0);
    chk("restart c1 addr", addr0, 32'h2);

    @(negedge clk); #1;
    chk("restart c2 valid", {31'b0, valid0}, 32'h1);
    chk("restart c2 pc", pc0, 32'h0);
    chk("restart c2 instr", {16'b0, instr0}, 32'h1000);

    @(negedge clk); #1;
    chk("restart c3 pc", pc0, 32'h2);
    chk("restart c3 instr", {16'b0, instr0}, 32'h1002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined ARM CPU: owns the PC, issues requests to the synchronous instruction memory, and drives the IF/ID register consumed by decode. It obeys the hazard detector's stall (freeze PC and IF/ID without losing the in-flight instruction) and the EXE-stage branch redirect (squash wrong-path fetches). A one-entry skid buffer captures the memory response that lands while the pipeline is stalled.

## Interface
- PC_WIDTH, 32, PC and instruction-memory address width
- INSTR_WIDTH, 16, instruction width; PC step = INSTR_WIDTH/8
- RESET_PC, 0, first fetch address after reset

- clk_i  input  1  single clock, all state updates on rising edge
- rst_n_i  input  1  synchronous, active-low reset
- stall_pipeline_i  input  stall_pipeline_sig  from hazard detector; STALL_PIPELINE freezes fetch
- branch_taken_i  input  1  redirect request from EXE
- branch_target_i  input  PC_WIDTH  redirect address, valid with branch_taken_i
- imem_rd_en_o  output  1  read request this cycle
- imem_addr_o  output  PC_WIDTH  read address
- imem_data_i  input  INSTR_WIDTH  read data, valid the cycle after the request
- instr_o  output  INSTR_WIDTH  IF/ID instruction
- instr_pc_o  output  PC_WIDTH  IF/ID PC of instr_o
- instr_valid_o  output  1  IF/ID valid; 0 = bubble

## Operation
- State: pc_q, pending_q (request in flight) + pending_pc_q, skid buffer (valid, instr, pc), IF/ID register.
- Reset (rst_n_i low at edge): pc_q=RESET_PC, pending_q=0, skid empty, instr_valid_o=0, instr_o=0, instr_pc_o=0. imem_rd_en_o is 0 while rst_n_i is low.
- Normal cycle (no stall, no branch): imem_rd_en_o=1, imem_addr_o=pc_q; pc_q += step; pending set with pending_pc_q=pc_q. IF/ID loads skid entry if skid valid (skid then cleared), else loads the returning response (imem_data_i, pending_pc_q) with valid=pending_q.
- Stall cycle: imem_rd_en_o=0; pc_q and IF/ID hold. A response returning this cycle (pending_q=1) is written to the skid buffer; pending_q cleared. Skid holds across multi-cycle stalls.
- Branch cycle (branch_taken_i=1): highest priority, overrides stall. imem_rd_en_o=1, imem_addr_o=branch_target_i, pc_q=branch_target_i+step, pending_pc_q=branch_target_i. Returning response discarded, skid cleared, instr_valid_o=0 next cycle.
- PC arithmetic modulo 2^PC_WIDTH; wrap from all-ones is silent. Low address bits are not checked.
- At most one request in flight; skid depth 1 is sufficient by construction.

## Timing
- Fetch latency: request cycle T -> data at imem_data_i in T+1 -> visible on instr_o in T+2.
- Steady state: one valid instruction per cycle.
- Stall asserted in cycle S: IF/ID unchanged in S+1; released in cycle U: skid entry visible in U+1, next sequential instruction in U+2, no bubble.
- Branch asserted in T: instr_valid_o=0 in T+1, target instruction valid in T+2 (one bubble, one squashed fetch).
- First valid instruction appears 2 cycles after the first cycle with rst_n_i high.
- Reset mid-stall or mid-branch: reset wins; all state returns to reset values.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs stall_cycles_o[31:0] (cycles with stall and no branch) and redirect_cnt_o[31:0] (branch cycles). Both saturate at all-ones and reset to 0.
- Undefined: neither port nor counter logic exists. Fetch behaviour is identical in both builds.

## Structure
- GENERAL_DEFS package: stall_pipeline_sig with STALL_PIPELINE/NO_STALL_PIPELINE (shared with hazard detector). New fetch_entry_t struct {instr, pc} used by skid and IF/ID.
- Sub-module fetch_skid_buffer: one fetch_entry_t entry, load/clear/valid. Top holds PC, pending tracking, IF/ID, muxing.

## Test plan
- Reset release, memory returns 0x1000+addr: instr_pc_o = 0,2,4,... valid from cycle 2, one per cycle.
- Stall for 3 cycles while request at PC 0x8 in flight: IF/ID frozen at 0x6, then 0x8 from skid, then 0xA with no gap.
- Branch to 0x40 from steady state: one bubble, then instr_pc_o 0x40,0x42; wrong-path 0x(n+2) never valid.
- Branch and stall asserted together with skid full: branch wins, skid cleared, 0x40 valid two cycles later.
- RESET_PC=0xFFFFFFFC: PC sequence 0xFFFFFFFC, 0xFFFFFFFE, 0x0.
- rst_n_i low for one cycle during stall: all outputs 0, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.
